// File: rtl/seq_dp_pkg.sv
// ============================================================================
// Module      : seq_dp_pkg
// Description : Shared opcodes, FSM state encoding and the step-count helper
//               for the seq_data_path accumulator datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package seq_dp_pkg;

  // Opcodes (3-bit OP field); 5..7 are reserved and behave as no-ops.
  localparam logic [2:0] OP_NEG  = 3'd0;
  localparam logic [2:0] OP_MULK = 3'd1;
  localparam logic [2:0] OP_DUP  = 3'd2;
  localparam logic [2:0] OP_ABS  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of EXEC steps an opcode needs. Reserved opcodes need none and go
  // straight from the accept edge to DONE.
  function automatic int op_steps(input logic [2:0] op, input int kw);
    case (op)
      OP_NEG, OP_DUP, OP_ABS, OP_ROL: return 1;
      OP_MULK:                        return kw;
      default:                        return 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_dp_step.sv
// ============================================================================
// Module      : seq_dp_step
// Description : Combinational ALU/shifter for seq_data_path. Produces the
//               value loaded into REG on the accept edge and the value of one
//               EXEC step applied to REG.
// Config      : SEQ_DP_OVF_EN adds the step_ovf output (overflow of a step).
// Ports       : ld_op/inp    - incoming opcode and operand (load value)
//               op/reg_val/opnd/shamt/cycle - latched context for a step
//               load_val     - REG value on accept
//               step_val     - REG value after one step
//               step_ovf     - step overflowed (SEQ_DP_OVF_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_dp_step
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MUL_K = 10,
  parameter int KW    = 4,
  parameter int CYCW  = 4
) (
  input  logic [2:0]               ld_op,
  input  logic [WIDTH-1:0]         inp,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         reg_val,
  input  logic [WIDTH-1:0]         opnd,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [CYCW-1:0]          cycle,
  output logic [WIDTH-1:0]         load_val,
  output logic [WIDTH-1:0]         step_val
`ifdef SEQ_DP_OVF_EN
  ,
  output logic                     step_ovf
`endif
);

  localparam logic [KW-1:0]    C_MULK     = KW'(MUL_K);
  localparam logic [WIDTH-1:0] C_LOW_MASK = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};

  logic mulk_bit;
  logic [WIDTH-1:0] rot;

`ifdef SEQ_DP_OVF_EN
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Double-width shift keeps the bits pushed out of OPND so they can be
  // reported; the extra sum bit is the carry out of the add.
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     sum;
`else
  logic [WIDTH-1:0]   shifted;
  logic [WIDTH-1:0]   sum;
`endif

  always_comb begin
    // Bit of MUL_K scanned by the current step
    mulk_bit = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (int'(cycle) == i) mulk_bit = C_MULK[i];
    end

`ifdef SEQ_DP_OVF_EN
    shifted = {{WIDTH{1'b0}}, opnd} << cycle;
    sum     = {1'b0, reg_val} + {1'b0, shifted[WIDTH-1:0]};
`else
    shifted = opnd << cycle;
    sum     = reg_val + shifted;
`endif

    // Rotate; a shift by WIDTH yields zero, so shamt=0 leaves reg_val intact
    rot = (reg_val << shamt) | (reg_val >> (32'(WIDTH) - 32'(shamt)));

    // Load value: reserved opcodes keep REG unchanged
    case (ld_op)
      OP_NEG:  load_val = ~inp;
      OP_MULK: load_val = '0;
      OP_DUP:  load_val = inp & C_LOW_MASK;
      OP_ABS:  load_val = inp;
      OP_ROL:  load_val = inp;
      default: load_val = reg_val;
    endcase

    step_val = reg_val;
`ifdef SEQ_DP_OVF_EN
    step_ovf = 1'b0;
`endif
    case (op)
      OP_NEG:  step_val = reg_val + WIDTH'(1);
      OP_MULK: begin
        if (mulk_bit) begin
          step_val = sum[WIDTH-1:0];
`ifdef SEQ_DP_OVF_EN
          step_ovf = sum[WIDTH] | (|shifted[2*WIDTH-1:WIDTH]);
`endif
        end
      end
      OP_DUP:  step_val = reg_val | (reg_val << (WIDTH/2));
      OP_ABS:  begin
        step_val = reg_val[WIDTH-1] ? (~reg_val + WIDTH'(1)) : reg_val;
`ifdef SEQ_DP_OVF_EN
        // The most negative value has no positive counterpart
        step_ovf = (reg_val == C_MIN);
`endif
      end
      OP_ROL:  step_val = rot;
      default: step_val = reg_val;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seq_data_path.sv
// ============================================================================
// Module      : seq_data_path
// Description : Handshaked accumulator datapath. START (in IDLE/DONE) latches
//               OP/INP/SHAMT and loads REG; the FSM then runs op_steps(OP)
//               EXEC steps through seq_dp_step and pulses DONE for one cycle.
// Config      : SEQ_DP_OVF_EN adds the sticky OVF output, valid with DONE.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               start    - request, honoured only in IDLE/DONE
//               op/inp/shamt - opcode, operand, rotate amount (with start)
//               busy     - sequence executing
//               done     - one-cycle completion pulse
//               reg_out  - accumulator contents
//               cycle    - EXEC step index, 0 outside EXEC
//               ovf      - overflow flag (SEQ_DP_OVF_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_data_path
  import seq_dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MUL_K = 10,
  parameter int KW    = 4,
  parameter int CYCW  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         inp,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         reg_out,
  output logic [CYCW-1:0]          cycle
`ifdef SEQ_DP_OVF_EN
  ,
  output logic                     ovf
`endif
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [SHW-1:0]   shamt_q, shamt_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [CYCW-1:0]  cycle_q, cycle_d;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;
  logic             accept;
  logic             last_step;

`ifdef SEQ_DP_OVF_EN
  logic ovf_q, ovf_d;
  logic step_ovf;
`endif

  seq_dp_step #(
    .WIDTH (WIDTH),
    .MUL_K (MUL_K),
    .KW    (KW),
    .CYCW  (CYCW)
  ) u_step (
    .ld_op    (op),
    .inp      (inp),
    .op       (op_q),
    .reg_val  (reg_q),
    .opnd     (opnd_q),
    .shamt    (shamt_q),
    .cycle    (cycle_q),
    .load_val (load_val),
    .step_val (step_val)
`ifdef SEQ_DP_OVF_EN
    ,
    .step_ovf (step_ovf)
`endif
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    shamt_d = shamt_q;
    reg_d   = reg_q;
    cycle_d = cycle_q;
`ifdef SEQ_DP_OVF_EN
    ovf_d   = ovf_q;
`endif

    accept    = start && (state_q != ST_EXEC);
    last_step = (int'(cycle_q) == op_steps(op_q, KW) - 1);

    if (accept) begin
      op_d    = op;
      opnd_d  = inp;
      shamt_d = shamt;
      reg_d   = load_val;
      cycle_d = '0;
`ifdef SEQ_DP_OVF_EN
      ovf_d   = 1'b0;
`endif
      // Zero-step (reserved) opcodes complete without entering EXEC
      state_d = (op_steps(op, KW) == 0) ? ST_DONE : ST_EXEC;
    end else begin
      case (state_q)
        ST_EXEC: begin
          reg_d = step_val;
`ifdef SEQ_DP_OVF_EN
          ovf_d = ovf_q | step_ovf;
`endif
          if (last_step) begin
            state_d = ST_DONE;
            cycle_d = '0;
          end else begin
            cycle_d = cycle_q + CYCW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      shamt_q <= '0;
      reg_q   <= '0;
      cycle_q <= '0;
`ifdef SEQ_DP_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      shamt_q <= shamt_d;
      reg_q   <= reg_d;
      cycle_q <= cycle_d;
`ifdef SEQ_DP_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy    = (state_q == ST_EXEC);
  assign done    = (state_q == ST_DONE);
  assign reg_out = reg_q;
  assign cycle   = cycle_q;
`ifdef SEQ_DP_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_data_path.sv
// ============================================================================
// Module      : tb_seq_data_path
// Description : Scoreboard bench for seq_data_path (WIDTH=8, MUL_K=10, KW=4).
//               The driver pushes expected results computed arithmetically;
//               a monitor pops and compares them whenever DONE is seen.
// Config      : SEQ_DP_OVF_EN also checks the OVF output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_data_path;

  localparam int WIDTH = 8;
  localparam int MUL_K = 10;
  localparam int KW    = 4;
  localparam int CYCW  = 4;
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = 1 << (WIDTH / 2);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] inp = '0;
  logic [2:0]       shamt = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] reg_out;
  logic [CYCW-1:0]  cycle;
`ifdef SEQ_DP_OVF_EN
  logic             ovf;
`endif

  seq_data_path #(
    .WIDTH (WIDTH),
    .MUL_K (MUL_K),
    .KW    (KW),
    .CYCW  (CYCW)
  ) dut (
`ifdef SEQ_DP_OVF_EN
    .ovf     (ovf),
`endif
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .inp     (inp),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .reg_out (reg_out),
    .cycle   (cycle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int ovf;
    int n;
    int dcyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   busy_cnt  = 0;
  int   model_reg = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results from the arithmetic meaning of each opcode.
  function automatic void model(input int o, input int a, input int s,
                                inout int r, output int ov, output int n);
    ov = 0;
    case (o)
      0: begin r = (MOD - a) % MOD; n = 1; end
      1: begin r = (a * MUL_K) % MOD; ov = int'(a * MUL_K >= MOD); n = KW; end
      2: begin r = (a % HALF) * (HALF + 1); n = 1; end
      3: begin r = (a >= MOD / 2) ? (MOD - a) % MOD : a; ov = int'(a == MOD / 2); n = 1; end
      4: begin r = ((a << s) | (a >> (WIDTH - s))) % MOD; n = 1; end
      default: n = 0;
    endcase
  endfunction

  // Monitor: per-cycle BUSY/CYCLE consistency and result check on DONE
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) begin
        check("cycle_in_exec", 32'(cycle), busy_cnt);
        check("done_while_busy", 32'(done), 0);
        busy_cnt++;
      end else begin
        check("cycle_outside_exec", 32'(cycle), 0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 required no pending op (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("result", 32'(reg_out), e.val);
          check("done_latency", cyc, e.dcyc);
          check("busy_cycles", busy_cnt, e.n);
`ifdef SEQ_DP_OVF_EN
          check("ovf", 32'(ovf), e.ovf);
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one operation at a negedge in IDLE/DONE; returns at the DONE negedge.
  // With junk set, START is held with random payload during EXEC.
  task automatic run_op(input int o, input int a, input int s, input bit junk);
    int   r, ov, n;
    exp_t e;
    op    = 3'(o);
    inp   = WIDTH'(a);
    shamt = 3'(s);
    start = 1'b1;
    r = model_reg;
    model(o, a, s, r, ov, n);
    model_reg = r;
    e.val  = r;
    e.ovf  = ov;
    e.n    = n;
    e.dcyc = cyc + 1 + n;
    sb.push_back(e);
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      start = 1'b0;
      if (done) break;
      if (junk && busy) begin
        start = 1'b1;
        op    = 3'($urandom);
        inp   = WIDTH'($urandom);
        shamt = 3'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done for op %0d required done within bound", o);
    end
  endtask

  initial begin
    bit reached;
    repeat (2) @(negedge clk);
    check("rst_reg_out", 32'(reg_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cycle", 32'(cycle), 0);
`ifdef SEQ_DP_OVF_EN
    check("rst_ovf", 32'(ovf), 0);
`endif
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases, mostly back-to-back (accepted in the DONE cycle)
    run_op(0, 'h05, 0, 1'b0);
    repeat (2) @(negedge clk);
    run_op(1, 'h07, 0, 1'b1);
    run_op(1, 'h1A, 0, 1'b0);
    run_op(2, 'hA7, 0, 1'b0);
    run_op(4, 'h81, 1, 1'b0);
    run_op(4, 'h5A, 0, 1'b0);
    run_op(3, 'h80, 0, 1'b0);
    run_op(3, 'h05, 0, 1'b0);
    run_op(6, 'h33, 0, 1'b0);
    repeat (1) @(negedge clk);
    run_op(7, 'h12, 3, 1'b0);

    // Asynchronous reset in the middle of a MULK sequence
    op    = 3'd1;
    inp   = 8'h07;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (busy && cycle == 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_mulk_step2", 32'(reached), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_reg_out", 32'(reg_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_cycle", 32'(cycle), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    model_reg = 0;
    repeat (4) @(negedge clk);
    run_op(0, 'h01, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int o, a, s, gap;
      o   = $urandom_range(0, 7);
      a   = $urandom_range(0, MOD - 1);
      s   = $urandom_range(0, WIDTH - 1);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(o, a, s, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
